// File: rtl/audio_clk_pkg.sv
// Shared types and helpers for the audio sample-clock sequencer.
// Rate codes, FSM states and the rate-to-divider mapping live here.
package audio_clk_pkg;

   typedef enum logic [1:0] {
      RATE_X1 = 2'd0,
      RATE_X2 = 2'd1,
      RATE_X4 = 2'd2,
      RATE_X8 = 2'd3
   } rate_t;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_SETTLE = 2'd3
   } state_t;

   localparam int FRAME_BCLKS = 64;

   // Master clocks per bit-clock strobe: 8 at x1 down to 1 at x8.
   function automatic logic [3:0] rate_to_div(input rate_t rate);
      return 4'd8 >> rate;
   endfunction

endpackage

// File: rtl/audio_bclk_counter.sv
// Bit-clock divider and frame position counter.
// Produces the bit-clock strobe, the word clock and the frame-wrap flag.
module audio_bclk_counter
   import audio_clk_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       load,
   input  logic [3:0] div,
   output logic       bclk_stb,
   output logic       lrclk,
   output logic       frame_start
);

   logic [2:0] div_cnt;
   logic [5:0] bit_cnt;
   logic [2:0] div_last;

   assign div_last = 3'(div - 4'd1);

   // NOTE: non-blocking assignments so every counter advances from its pre-edge value.
   always_ff @(posedge clk) begin
      if (reset || load || !run) begin
         div_cnt  <= 3'd0;
         bit_cnt  <= 6'd0;
         bclk_stb <= 1'b0;
      end else begin
         div_cnt  <= (div_cnt == div_last) ? 3'd0 : div_cnt + 3'd1;
         bclk_stb <= (div_cnt == div_last);
         if (bclk_stb) begin
            bit_cnt <= bit_cnt + 6'd1;
         end
      end
   end

   assign lrclk       = bit_cnt[5];
   assign frame_start = bclk_stb && (bit_cnt == 6'(FRAME_BCLKS - 1));

endmodule

// File: rtl/audio_clock_ctrl.sv
// Audio sample-clock sequencer: accepts rate-change requests and applies
// them on a frame boundary, muting the audio path around every switch.
module audio_clock_ctrl
   import audio_clk_pkg::*;
#(
   parameter logic [1:0]  RESET_RATE    = 2'd0,
   parameter int unsigned SETTLE_FRAMES = 2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       enable_i,
   input  logic       req_valid_i,
   input  logic [1:0] req_rate_i,
   output logic       req_ready_o,
   output logic       done_o,
   output logic [1:0] rate_o,
   output logic       mute_o,
   output logic       bclk_stb_o,
   output logic       lrclk_o,
   output logic       frame_start_o
);

   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE_FRAMES);

   state_t     state_q, state_d;
   rate_t      rate_q, rate_d;
   rate_t      pend_q, pend_d;
   logic [3:0] settle_q, settle_d;
   logic       from_req_q, from_req_d;
   logic       done_d;
   logic       load;
   logic       handshake;
   logic [3:0] div;

   assign req_ready_o = (state_q == ST_RUN) && enable_i;
   assign handshake   = req_valid_i && req_ready_o;
   assign rate_o      = rate_q;
   assign div         = rate_to_div(rate_q);

   audio_bclk_counter u_counter (
      .clk         (clk_i),
      .reset       (reset_i),
      .run         (state_q != ST_OFF),
      .load        (load),
      .div         (div),
      .bclk_stb    (bclk_stb_o),
      .lrclk       (lrclk_o),
      .frame_start (frame_start_o)
   );

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      rate_d     = rate_q;
      pend_d     = pend_q;
      settle_d   = settle_q;
      from_req_d = from_req_q;
      done_d     = 1'b0;
      load       = 1'b0;

      if (!enable_i) begin
         // A request caught mid-drain still lands, so the host sees it complete.
         if (state_q == ST_DRAIN) begin
            rate_d = pend_q;
            done_d = 1'b1;
         end
         state_d = ST_OFF;
      end else begin
         unique case (state_q)
            ST_OFF: begin
               state_d    = ST_SETTLE;
               settle_d   = SETTLE_CNT;
               from_req_d = 1'b0;
            end
            ST_RUN: begin
               if (handshake) begin
                  if (rate_t'(req_rate_i) != rate_q) begin
                     pend_d  = rate_t'(req_rate_i);
                     state_d = ST_DRAIN;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (frame_start_o) begin
                  rate_d     = pend_q;
                  load       = 1'b1;
                  settle_d   = SETTLE_CNT;
                  from_req_d = 1'b1;
                  state_d    = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (frame_start_o) begin
                  if (settle_q == 4'd1) begin
                     state_d = ST_RUN;
                     done_d  = from_req_q;
                  end else begin
                     settle_d = settle_q - 4'd1;
                  end
               end
            end
            default: state_d = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_OFF;
         rate_q     <= rate_t'(RESET_RATE);
         pend_q     <= rate_t'(RESET_RATE);
         settle_q   <= 4'd0;
         from_req_q <= 1'b0;
         done_o     <= 1'b0;
         mute_o     <= 1'b1;
      end else begin
         state_q    <= state_d;
         rate_q     <= rate_d;
         pend_q     <= pend_d;
         settle_q   <= settle_d;
         from_req_q <= from_req_d;
         done_o     <= done_d;
         mute_o     <= (state_d != ST_RUN);
      end
   end

endmodule
